// File: rtl/bsg_relay_serializer.sv
// Word-to-chunk serializer: accepts one width_p-bit word per handshake and emits it as
// els_p chunks, least-significant first, overlapping the next load with the last chunk.
module bsg_relay_serializer #(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p/els_p-1:0]   data_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int chunk_lp = width_p / els_p;
  localparam int cnt_w_lp = $clog2(els_p);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(els_p - 1);

  logic [width_p-1:0]  r_data;
  logic [cnt_w_lp-1:0] r_count;
  logic                r_v;

  logic [width_p-1:0]  w_data_nxt;
  logic [cnt_w_lp-1:0] w_count_nxt;
  logic                w_v_nxt;
  logic                w_last;
  logic                w_ready;
  logic                w_in_xfer;
  logic                w_out_xfer;

  assign w_last     = r_v & (r_count == last_cnt_lp);
  // ready_i feeds ready_o combinationally so the next word loads on the last-chunk beat
  assign w_ready    = reset_n_i & (~r_v | (ready_i & w_last));
  assign w_in_xfer  = v_i & w_ready;
  assign w_out_xfer = r_v & ready_i;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data  <= '0;
      r_count <= '0;
      r_v     <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
      r_v     <= w_v_nxt;
    end
  end

  // Next-state: a word load always wins, which is what keeps back-to-back words gapless
  always_comb begin
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_v_nxt     = r_v;
    if (w_in_xfer) begin
      w_data_nxt  = data_i;
      w_count_nxt = '0;
      w_v_nxt     = 1'b1;
    end else if (w_out_xfer) begin
      if (w_last) begin
        w_count_nxt = '0;
        w_v_nxt     = 1'b0;
      end else begin
        w_count_nxt = r_count + cnt_w_lp'(1);
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Outputs
  always_comb begin
    ready_o = w_ready;
    v_o     = r_v;
    last_o  = w_last;
    data_o  = r_data[r_count*chunk_lp +: chunk_lp];
  end

endmodule
